// File: rtl/collatz_pkg.sv
// Shared types for the Collatz orbit engine: result status codes and FSM states.
package collatz_pkg;

    localparam int STATUS_W = 2;

    // Termination reason reported alongside each result.
    typedef enum logic [STATUS_W-1:0] {
        ST_OK   = 2'd0,  // orbit reached 1
        ST_ZERO = 2'd1,  // seed was 0, no orbit exists
        ST_OVF  = 2'd2,  // next odd step would not fit in the iterate width
        ST_SAT  = 2'd3   // orbit-length counter reached all-ones
    } status_e;

    // Engine control states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/collatz_step.sv
// One combinational Collatz step with overflow detection.
// 3n+1 is formed two bits wider than the iterate, so overflow can be read from the top bits.
module collatz_step #(
    parameter int BITS = 144
) (
    input  logic [BITS-1:0] n,
    input  logic            shortcut,
    output logic [BITS-1:0] next_n,
    output logic            is_odd,
    output logic            ovf,
    output logic            is_one,
    output logic            is_zero
);

    localparam logic [BITS+1:0] ONE_W = 1;
    localparam logic [BITS-1:0] ONE_N = 1;

    logic [BITS+1:0] triple;  // 3n+1, never truncated
    logic [BITS:0]   halved;  // (3n+1)/2, one bit wider than the iterate

    assign triple  = {2'b00, n} + {1'b0, n, 1'b0} + ONE_W;
    assign halved  = triple[BITS+1:1];
    assign is_odd  = n[0];
    assign is_zero = (n == '0);
    assign is_one  = (n == ONE_N);

    // Select the successor and flag an odd step whose result does not fit in BITS.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_n = n >> 1;
        ovf    = 1'b0;
        if (is_odd) begin
            if (shortcut) begin
                next_n = halved[BITS-1:0];
                ovf    = halved[BITS];
            end else begin
                next_n = triple[BITS-1:0];
                ovf    = |triple[BITS+1:BITS];
            end
        end
    end

endmodule

// File: rtl/collatz_orbit_engine.sv
// Collatz orbit engine: takes a seed, iterates one step per clock, and returns
// orbit length, odd-step count, peak value and termination status.
// The result registers double as the working counters; they are final only in DONE.
module collatz_orbit_engine
    import collatz_pkg::*;
#(
    parameter int BITS      = 144,
    parameter int OLEN_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BITS-1:0]      in_seed,
    input  logic                 in_shortcut,
    input  logic                 abort,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OLEN_BITS-1:0] out_orbit_len,
    output logic [OLEN_BITS-1:0] out_odd_steps,
    output logic [BITS-1:0]      out_peak,
    output logic [1:0]           out_status
);

    localparam logic [OLEN_BITS-1:0] LEN_MAX = '1;
    localparam logic [OLEN_BITS-1:0] LEN_ONE = 1;

    state_e          state;
    logic [BITS-1:0] n_q;
    logic            shortcut_q;

    logic [BITS-1:0] step_next;
    logic            step_odd;
    logic            step_ovf;
    logic            step_one;
    logic            step_zero;

    collatz_step #(
        .BITS(BITS)
    ) u_step (
        .n        (n_q),
        .shortcut (shortcut_q),
        .next_n   (step_next),
        .is_odd   (step_odd),
        .ovf      (step_ovf),
        .is_one   (step_one),
        .is_zero  (step_zero)
    );

    // Control FSM, handshake flags, iterate and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the reset branch clears every register here; these are plain flops, not a memory array.
        if (!rst_n) begin
            state         <= S_IDLE;
            n_q           <= '0;
            shortcut_q    <= 1'b0;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            out_orbit_len <= '0;
            out_odd_steps <= '0;
            out_peak      <= '0;
            out_status    <= ST_OK;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    // abort in IDLE suppresses a simultaneous seed
                    if (!abort && in_valid) begin
                        n_q           <= in_seed;
                        shortcut_q    <= in_shortcut;
                        out_orbit_len <= '0;
                        out_odd_steps <= '0;
                        out_peak      <= in_seed;
                        out_status    <= ST_OK;
                        in_ready      <= 1'b0;
                        busy          <= 1'b1;
                        state         <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end else if (step_zero || step_one || (step_odd && step_ovf)
                                 || (out_orbit_len == LEN_MAX)) begin
                        // Terminating evaluation: n is left as is, only the status is recorded.
                        if (step_zero) begin
                            out_status <= ST_ZERO;
                        end else if (step_one) begin
                            out_status <= ST_OK;
                        end else if (step_odd && step_ovf) begin
                            out_status <= ST_OVF;
                        end else begin
                            out_status <= ST_SAT;
                        end
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        n_q           <= step_next;
                        out_orbit_len <= out_orbit_len + LEN_ONE;
                        // odd never passes len: it only counts steps that len also counts
                        if (step_odd) begin
                            out_odd_steps <= out_odd_steps + LEN_ONE;
                        end
                        // peak tracks stored values only, never the unstored 3n+1 of shortcut mode
                        if (step_next > out_peak) begin
                            out_peak <= step_next;
                        end
                    end
                end

                S_DONE: begin
                    if (abort || out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collatz_orbit_engine.sv
// Self-checking bench for collatz_orbit_engine. Three instances cover the wide
// default, a 16-bit iterate (overflow) and a 4-bit length counter (saturation).
// Expected results come from an arithmetic orbit model.
module tb_collatz_orbit_engine;
    import collatz_pkg::*;

    localparam int BW = 144;
    localparam int RW = 16 + 16 + BW + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic          in_shortcut;
    logic          abort;
    logic          out_ready;
    logic [BW-1:0] in_seed;
    int            sel;

    int total = 0;
    int bad   = 0;

    // instance 0: BITS=144, OLEN_BITS=16
    logic          ir0, bz0, ov0;
    logic [15:0]   ol0, od0;
    logic [BW-1:0] pk0;
    logic [1:0]    st0;
    // instance 1: BITS=16, OLEN_BITS=16
    logic          ir1, bz1, ov1;
    logic [15:0]   ol1, od1;
    logic [15:0]   pk1;
    logic [1:0]    st1;
    // instance 2: BITS=144, OLEN_BITS=4
    logic          ir2, bz2, ov2;
    logic [3:0]    ol2, od2;
    logic [BW-1:0] pk2;
    logic [1:0]    st2;

    collatz_orbit_engine #(.BITS(BW), .OLEN_BITS(16)) u_wide (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(ir0),
        .in_seed(in_seed), .in_shortcut(in_shortcut), .abort(abort), .busy(bz0),
        .out_valid(ov0), .out_ready(out_ready), .out_orbit_len(ol0), .out_odd_steps(od0),
        .out_peak(pk0), .out_status(st0)
    );

    collatz_orbit_engine #(.BITS(16), .OLEN_BITS(16)) u_narrow (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(ir1),
        .in_seed(in_seed[15:0]), .in_shortcut(in_shortcut), .abort(abort), .busy(bz1),
        .out_valid(ov1), .out_ready(out_ready), .out_orbit_len(ol1), .out_odd_steps(od1),
        .out_peak(pk1), .out_status(st1)
    );

    collatz_orbit_engine #(.BITS(BW), .OLEN_BITS(4)) u_short_len (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(ir2),
        .in_seed(in_seed), .in_shortcut(in_shortcut), .abort(abort), .busy(bz2),
        .out_valid(ov2), .out_ready(out_ready), .out_orbit_len(ol2), .out_odd_steps(od2),
        .out_peak(pk2), .out_status(st2)
    );

    // Outputs of the instance under test, zero-extended to common widths.
    logic          obs_ready, obs_busy, obs_valid;
    logic [15:0]   obs_len, obs_odd;
    logic [BW-1:0] obs_peak;
    logic [1:0]    obs_status;

    always_comb begin
        obs_ready  = ir0;
        obs_busy   = bz0;
        obs_valid  = ov0;
        obs_len    = ol0;
        obs_odd    = od0;
        obs_peak   = pk0;
        obs_status = st0;
        if (sel == 1) begin
            obs_ready  = ir1;
            obs_busy   = bz1;
            obs_valid  = ov1;
            obs_len    = ol1;
            obs_odd    = od1;
            obs_peak   = {{(BW-16){1'b0}}, pk1};
            obs_status = st1;
        end else if (sel == 2) begin
            obs_ready  = ir2;
            obs_busy   = bz2;
            obs_valid  = ov2;
            obs_len    = {12'd0, ol2};
            obs_odd    = {12'd0, od2};
            obs_peak   = pk2;
            obs_status = st2;
        end
    end

    function automatic logic [RW-1:0] pack(input int len, input int odd,
                                           input logic [BW-1:0] peak, input logic [1:0] st);
        return {16'(len), 16'(odd), peak, st};
    endfunction

    // Orbit model straight from the Collatz rules with wide plain arithmetic.
    function automatic void model(input logic [BW-1:0] seed, input bit sc, input int bits,
                                  input int olen_bits, output logic [RW-1:0] res, output int len);
        logic [BW+1:0] n, t, lim;
        logic [BW-1:0] peak;
        logic [1:0]    st;
        int            odd, cap;
        n    = {2'b00, seed};
        peak = seed;
        len  = 0;
        odd  = 0;
        cap  = (1 << olen_bits) - 1;
        lim  = '0;
        lim[bits] = 1'b1;
        st   = ST_OK;
        t    = '0;
        while (1) begin
            if (n == 0) begin st = ST_ZERO; break; end
            if (n == 1) begin st = ST_OK; break; end
            if (n[0]) begin
                t = n * 3 + 1;
                if (sc) t = t / 2;
                if (t >= lim) begin st = ST_OVF; break; end
            end
            if (len == cap) begin st = ST_SAT; break; end
            if (n[0]) begin
                n = t;
                odd++;
            end else begin
                n = n / 2;
            end
            len++;
            if (n > {2'b00, peak}) peak = n[BW-1:0];
        end
        res = pack(len, odd, peak, st);
    endfunction

    // Offer a seed from IDLE, wait for out_valid, optionally take the result.
    task automatic run_seed(input logic [BW-1:0] seed, input bit sc, input int limit,
                            input bit do_release, output logic [RW-1:0] res, output int cycles,
                            output bit timed_out, output bit busy_seen, output bit idle_after);
        in_seed     = seed;
        in_shortcut = sc;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        busy_seen = obs_busy;
        cycles    = 0;
        while (!obs_valid && cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
        end
        timed_out  = !obs_valid;
        res        = {obs_len, obs_odd, obs_peak, obs_status};
        idle_after = 1'b0;
        if (do_release) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready  = 1'b0;
            idle_after = obs_ready && !obs_valid && !obs_busy;
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            total++;
            if ({obs_ready, obs_busy, obs_valid, obs_len, obs_odd, obs_peak, obs_status}
                !== {3'b100, 16'd0, 16'd0, {BW{1'b0}}, 2'd0}) begin
                bad++;
                $display("FAIL reset_state inst=%0d got rdy=%b busy=%b vld=%b len=%0d odd=%0d peak=%h st=%0d",
                         s, obs_ready, obs_busy, obs_valid, obs_len, obs_odd, obs_peak, obs_status);
            end
        end
        sel = 0;
    endtask

    task automatic test_known_seeds();
        logic [RW-1:0] res, exp;
        int cyc, elen;
        bit to, bs, ia;
        sel = 0;
        run_seed(144'd27, 1'b0, 300, 1'b1, res, cyc, to, bs, ia);
        total++;
        if (res !== pack(111, 41, 144'd9232, ST_OK)) begin
            bad++; $display("FAIL seed27_std got=%h exp=%h", res, pack(111, 41, 144'd9232, ST_OK));
        end
        total++;
        if (to || cyc != 112) begin
            bad++; $display("FAIL seed27_latency got=%0d exp=112 timeout=%b", cyc, to);
        end
        total++;
        if (!bs || !ia) begin
            bad++; $display("FAIL seed27_handshake got busy=%b idle_after=%b exp 1 1", bs, ia);
        end
        run_seed(144'd27, 1'b1, 300, 1'b1, res, cyc, to, bs, ia);
        model(144'd27, 1'b1, BW, 16, exp, elen);
        total++;
        if (res[RW-1 -: 32] !== {16'd70, 16'd41} || res[1:0] !== ST_OK || res !== exp) begin
            bad++; $display("FAIL seed27_shortcut got=%h exp=%h", res, exp);
        end
        run_seed(144'd1, 1'b0, 20, 1'b1, res, cyc, to, bs, ia);
        total++;
        if (res !== pack(0, 0, 144'd1, ST_OK) || cyc != 1) begin
            bad++; $display("FAIL seed1 got=%h cyc=%0d exp=%h cyc=1", res, cyc, pack(0, 0, 144'd1, ST_OK));
        end
        run_seed(144'd0, 1'b1, 20, 1'b1, res, cyc, to, bs, ia);
        total++;
        if (res !== pack(0, 0, 144'd0, ST_ZERO) || cyc != 1) begin
            bad++; $display("FAIL seed0 got=%h cyc=%0d exp=%h cyc=1", res, cyc, pack(0, 0, 144'd0, ST_ZERO));
        end
    endtask

    task automatic test_overflow();
        logic [RW-1:0] res, exp;
        logic [BW-1:0] seed;
        int cyc, elen;
        bit to, bs, ia, sc;
        sel = 1;
        run_seed(144'hFFFF, 1'b0, 20, 1'b1, res, cyc, to, bs, ia);
        total++;
        if (res !== pack(0, 0, 144'hFFFF, ST_OVF) || cyc != 1) begin
            bad++; $display("FAIL ovf_ffff got=%h cyc=%0d exp=%h", res, cyc, pack(0, 0, 144'hFFFF, ST_OVF));
        end
        run_seed(144'd27, 1'b0, 300, 1'b1, res, cyc, to, bs, ia);
        total++;
        if (res !== pack(111, 41, 144'd9232, ST_OK)) begin
            bad++; $display("FAIL narrow_seed27 got=%h exp=%h", res, pack(111, 41, 144'd9232, ST_OK));
        end
        for (int i = 0; i < 10; i++) begin
            seed = BW'($urandom_range(0, 65535));
            sc   = 1'($urandom);
            model(seed, sc, 16, 16, exp, elen);
            run_seed(seed, sc, elen + 20, 1'b1, res, cyc, to, bs, ia);
            total++;
            if (res !== exp || cyc != elen + 1 || !ia) begin
                bad++; $display("FAIL narrow_rand seed=%0d sc=%b got=%h cyc=%0d exp=%h cyc=%0d",
                                seed, sc, res, cyc, exp, elen + 1);
            end
        end
        sel = 0;
    endtask

    task automatic test_saturation();
        logic [RW-1:0] res, exp;
        int cyc, elen;
        bit to, bs, ia;
        sel = 2;
        run_seed(144'd27, 1'b0, 40, 1'b1, res, cyc, to, bs, ia);
        total++;
        if (res !== pack(15, 7, 144'd484, ST_SAT) || cyc != 16) begin
            bad++; $display("FAIL sat_seed27 got=%h cyc=%0d exp=%h cyc=16", res, cyc, pack(15, 7, 144'd484, ST_SAT));
        end
        model(144'd7, 1'b0, BW, 4, exp, elen);
        run_seed(144'd7, 1'b0, 40, 1'b1, res, cyc, to, bs, ia);
        total++;
        if (res !== exp || res[1:0] !== ST_SAT) begin
            bad++; $display("FAIL sat_seed7 got=%h exp=%h", res, exp);
        end
        sel = 0;
    endtask

    task automatic test_abort();
        logic [RW-1:0] res;
        int cyc;
        bit to, bs, ia, seen;
        sel = 0;
        in_seed  = 144'd27;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++;
        if ({obs_ready, obs_busy, obs_valid} !== 3'b100) begin
            bad++; $display("FAIL abort_run got rdy/busy/vld=%b exp=100", {obs_ready, obs_busy, obs_valid});
        end
        seen = 1'b0;
        repeat (150) begin
            @(posedge clk); #1;
            if (obs_valid) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL abort_no_result got out_valid seen=1 exp=0");
        end
        run_seed(144'd7, 1'b0, 40, 1'b1, res, cyc, to, bs, ia);
        total++;
        if (res !== pack(16, 5, 144'd52, ST_OK) || cyc != 17) begin
            bad++; $display("FAIL after_abort_seed7 got=%h cyc=%0d exp=%h cyc=17", res, cyc, pack(16, 5, 144'd52, ST_OK));
        end
        in_seed  = 144'd7;
        in_valid = 1'b1;
        abort    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        total++;
        if ({obs_ready, obs_busy} !== 2'b10) begin
            bad++; $display("FAIL abort_idle got rdy/busy=%b exp=10", {obs_ready, obs_busy});
        end
    endtask

    task automatic test_hold_done();
        logic [RW-1:0] res, now;
        int cyc;
        bit to, bs, ia;
        sel = 0;
        run_seed(144'd27, 1'b0, 300, 1'b0, res, cyc, to, bs, ia);
        in_seed  = 144'd5;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            now = {obs_len, obs_odd, obs_peak, obs_status};
            total++;
            if (now !== pack(111, 41, 144'd9232, ST_OK) || {obs_valid, obs_ready, obs_busy} !== 3'b100) begin
                bad++; $display("FAIL hold_done cyc=%0d got=%h flags=%b exp=%h flags=100",
                                k, now, {obs_valid, obs_ready, obs_busy}, pack(111, 41, 144'd9232, ST_OK));
            end
        end
        in_valid = 1'b0;
        abort    = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({obs_valid, obs_ready, obs_busy} !== 3'b010) begin
            bad++; $display("FAIL abort_done got vld/rdy/busy=%b exp=010", {obs_valid, obs_ready, obs_busy});
        end
    endtask

    task automatic test_random_wide();
        logic [RW-1:0] res, exp;
        logic [BW-1:0] seed, ones;
        int cyc, elen, w;
        bit to, bs, ia, sc;
        sel  = 0;
        ones = '1;
        for (int i = 0; i < 12; i++) begin
            seed = '0;
            for (int k = 0; k < 5; k++) seed = (seed << 32) | BW'($urandom);
            w    = $urandom_range(1, BW);
            seed = seed & (ones >> (BW - w));
            sc   = 1'($urandom);
            model(seed, sc, BW, 16, exp, elen);
            run_seed(seed, sc, elen + 20, 1'b1, res, cyc, to, bs, ia);
            total++;
            if (res !== exp || cyc != elen + 1 || !ia) begin
                bad++; $display("FAIL wide_rand seed=%h sc=%b got=%h cyc=%0d exp=%h cyc=%0d",
                                seed, sc, res, cyc, exp, elen + 1);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        sel      = 0;
        in_seed  = 144'd27;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({obs_ready, obs_busy, obs_valid, obs_len, obs_odd, obs_peak, obs_status}
            !== {3'b100, 16'd0, 16'd0, {BW{1'b0}}, 2'd0}) begin
            bad++; $display("FAIL reset_mid_run got rdy=%b busy=%b vld=%b len=%0d odd=%0d peak=%h st=%0d",
                            obs_ready, obs_busy, obs_valid, obs_len, obs_odd, obs_peak, obs_status);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_shortcut = 1'b0;
        abort       = 1'b0;
        out_ready   = 1'b0;
        in_seed     = '0;
        sel         = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        test_reset();
        test_known_seeds();
        test_overflow();
        test_saturation();
        test_abort();
        test_hold_done();
        test_random_wide();
        test_reset_mid_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
